// File: rtl/alert_trigger_gen_if.sv
// Bundle of the raw sensor inputs and the set/clear/status outputs of alert_trigger_gen.
// The slave modport is the trigger generator; the master modport is whatever drives the raw inputs.
interface alert_trigger_gen_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             ack_raw;
    logic             arm_raw;
    logic             a;
    logic             b;
    logic [1:0]       state;
    logic [CNT_W-1:0] trig_cnt;

    modport master (
        output sensor_raw, ack_raw, arm_raw,
        input  a, b, state, trig_cnt
    );

    modport slave (
        input  sensor_raw, ack_raw, arm_raw,
        output a, b, state, trig_cnt
    );
endinterface

// File: rtl/alert_trigger_gen.sv
// Synchronizes and debounces sensor/ack/arm, runs the arm/exit-delay/trigger FSM and
// emits one-cycle, mutually exclusive set (a) and clear (b) pulses for alert_module.
module alert_trigger_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ARM_DELAY       = 8,
    parameter int CNT_W           = 8
) (
    input logic              clk,
    input logic              rst,
    alert_trigger_gen_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int EX_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [EX_W-1:0] EX_LOAD = EX_W'(ARM_DELAY - 1);

    typedef enum logic [1:0] {
        DISARMED  = 2'd0,
        ARMING    = 2'd1,
        ARMED     = 2'd2,
        TRIGGERED = 2'd3
    } state_t;

    // Bit 0 sensor, bit 1 ack, bit 2 arm.
    logic [2:0] raw;
    logic [2:0] stable;

    assign raw = {bus.arm_raw, bus.ack_raw, bus.sensor_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_in
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        stable_reg <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    logic stable_sensor;
    logic stable_ack;
    logic stable_arm;
    logic ack_prev_reg;
    logic ack_rise;

    assign stable_sensor = stable[0];
    assign stable_ack    = stable[1];
    assign stable_arm    = stable[2];
    assign ack_rise      = stable_ack & ~ack_prev_reg;

    state_t           state_reg;
    state_t           state_next;
    logic [EX_W-1:0]  exit_reg;
    logic [EX_W-1:0]  exit_next;
    logic             a_reg;
    logic             b_reg;
    logic             a_next;
    logic             b_next;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= DISARMED;
            exit_reg     <= '0;
            a_reg        <= 1'b0;
            b_reg        <= 1'b0;
            cnt_reg      <= '0;
            ack_prev_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            exit_reg     <= exit_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            ack_prev_reg <= stable_ack;
            if (a_next && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Arm-drop is checked first in every armed state so it always wins.
    always_comb begin
        state_next = state_reg;
        exit_next  = exit_reg;
        case (state_reg)
            DISARMED: begin
                if (stable_arm) begin
                    state_next = ARMING;
                    exit_next  = EX_LOAD;
                end
            end
            ARMING: begin
                if (!stable_arm) begin
                    state_next = DISARMED;
                end else if (exit_reg == '0) begin
                    state_next = ARMED;
                end else begin
                    exit_next = exit_reg - EX_W'(1);
                end
            end
            ARMED: begin
                if (!stable_arm) begin
                    state_next = DISARMED;
                end else if (stable_sensor) begin
                    state_next = TRIGGERED;
                end
            end
            TRIGGERED: begin
                if (!stable_arm) begin
                    state_next = DISARMED;
                end else if (ack_rise) begin
                    state_next = ARMED;
                end
            end
            default: state_next = DISARMED;
        endcase
    end

    always_comb begin
        a_next = 1'b0;
        b_next = 1'b0;
        case (state_reg)
            ARMED: begin
                b_next = ~stable_arm;
                a_next = stable_arm & stable_sensor;
            end
            TRIGGERED: begin
                b_next = ~stable_arm | ack_rise;
            end
            default: begin
                a_next = 1'b0;
                b_next = 1'b0;
            end
        endcase
    end

    assign bus.a        = a_reg;
    assign bus.b        = b_reg;
    assign bus.state    = state_reg;
    assign bus.trig_cnt = cnt_reg;
endmodule

// File: tb/tb_alert_trigger_gen.sv
// Randomized and directed bench for alert_trigger_gen; two instances (8-bit and 2-bit counter)
// share stimulus and are compared every cycle against a window-based behavioural model.
module tb_alert_trigger_gen;
    localparam int D  = 4;
    localparam int AD = 8;

    logic clk;
    logic rst;
    logic sensor_raw;
    logic ack_raw;
    logic arm_raw;

    alert_trigger_gen_if #(.CNT_W(8)) if8 ();
    alert_trigger_gen_if #(.CNT_W(2)) if2 ();

    assign if8.sensor_raw = sensor_raw;
    assign if8.ack_raw    = ack_raw;
    assign if8.arm_raw    = arm_raw;
    assign if2.sensor_raw = sensor_raw;
    assign if2.ack_raw    = ack_raw;
    assign if2.arm_raw    = arm_raw;

    alert_trigger_gen #(.DEBOUNCE_CYCLES(D), .ARM_DELAY(AD), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(if8)
    );
    alert_trigger_gen #(.DEBOUNCE_CYCLES(D), .ARM_DELAY(AD), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: sync = 2-cycle delay, stable flips once the last D synchronized
    // samples all disagree with it, FSM tracks elapsed ARMING cycles.
    bit         m_s1 [3];
    bit         m_s2 [3];
    bit         m_stab [3];
    bit [D-1:0] m_hist [3];
    bit         m_ack_rose;
    int         m_state;
    int         m_elapsed;
    bit         m_a;
    bit         m_b;
    int         m_cnt8;
    int         m_cnt2;

    int cyc        = 0;
    int a_total    = 0;
    int b_total    = 0;
    int last_a_cyc = -1;
    int last_b_cyc = -1;

    task automatic model_step();
        bit r [3];
        bit arm, sens, nstab;
        r[0] = sensor_raw;
        r[1] = ack_raw;
        r[2] = arm_raw;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_hist[i] = '0;
            end
            m_ack_rose = 0; m_state = 0; m_elapsed = 0;
            m_a = 0; m_b = 0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        arm  = m_stab[2];
        sens = m_stab[0];
        m_a  = 0;
        m_b  = 0;
        case (m_state)
            0: if (arm) begin m_state = 1; m_elapsed = 0; end
            1: begin
                if (!arm) m_state = 0;
                else if (m_elapsed == AD - 1) m_state = 2;
                else m_elapsed++;
            end
            2: begin
                if (!arm) begin m_state = 0; m_b = 1; end
                else if (sens) begin m_state = 3; m_a = 1; end
            end
            default: begin
                if (!arm) begin m_state = 0; m_b = 1; end
                else if (m_ack_rose) begin m_state = 2; m_b = 1; end
            end
        endcase
        if (m_a) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        m_ack_rose = 0;
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
            nstab = m_stab[i];
            if (m_hist[i] == {D{~m_stab[i]}}) nstab = m_s2[i];
            if (i == 1 && nstab && !m_stab[i]) m_ack_rose = 1;
            m_stab[i] = nstab;
            m_s2[i] = m_s1[i];
            m_s1[i] = r[i];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            cyc++;
            if (if8.a) begin a_total++; last_a_cyc = cyc; end
            if (if8.b) begin b_total++; last_b_cyc = cyc; end
            check("state", int'(if8.state), m_state);
            check("a", int'(if8.a), int'(m_a));
            check("b", int'(if8.b), int'(m_b));
            check("trig_cnt8", int'(if8.trig_cnt), m_cnt8);
            check("trig_cnt2", int'(if2.trig_cnt), m_cnt2);
            check("ab_exclusive", int'(if8.a & if8.b) + int'(if2.a & if2.b), 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int a0, b0, t1, t2;
    int h_sens, h_ack, h_arm;

    initial begin
        rst = 1'b0; sensor_raw = 0; ack_raw = 0; arm_raw = 0;
        cycles(3);
        rst = 1'b1;
        cycles(20);
        check("idle_state", int'(if8.state), 0);
        check("idle_pulses", a_total + b_total, 0);
        check("idle_cnt", int'(if8.trig_cnt), 0);

        // Exit delay: edge 0 is the first edge that samples arm_raw high.
        arm_raw = 1; t1 = -1; t2 = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (if8.state == 2'd1 && t1 < 0) t1 = k;
            if (if8.state == 2'd2 && t2 < 0) t2 = k;
        end
        check("arming_edge", t1, 6);
        check("armed_edge", t2, 14);

        a0 = a_total;
        sensor_raw = 1; cycles(3); sensor_raw = 0;
        cycles(15);
        check("glitch_no_a", a_total - a0, 0);
        check("glitch_cnt", int'(if8.trig_cnt), 0);

        a0 = a_total;
        sensor_raw = 1; cycles(15);
        check("trig_a", a_total - a0, 1);
        check("trig_state", int'(if8.state), 3);
        check("trig_cnt1", int'(if8.trig_cnt), 1);

        sensor_raw = 0; cycles(10);
        b0 = b_total;
        ack_raw = 1; cycles(6); ack_raw = 0; cycles(10);
        check("ack_b", b_total - b0, 1);
        check("ack_state", int'(if8.state), 2);
        check("ack_cnt", int'(if8.trig_cnt), 1);

        sensor_raw = 1; cycles(15);
        check("retrig_cnt", int'(if8.trig_cnt), 2);
        a0 = a_total; b0 = b_total;
        ack_raw = 1; cycles(6); ack_raw = 0; cycles(10);
        check("ackhigh_b", b_total - b0, 1);
        check("ackhigh_a", a_total - a0, 1);
        check("ackhigh_order", last_a_cyc - last_b_cyc, 1);
        check("ackhigh_state", int'(if8.state), 3);
        check("ackhigh_cnt", int'(if8.trig_cnt), 3);

        a0 = a_total; b0 = b_total;
        arm_raw = 0; ack_raw = 1; cycles(6); ack_raw = 0; cycles(10);
        check("simul_b", b_total - b0, 1);
        check("simul_a", a_total - a0, 0);
        check("simul_state", int'(if8.state), 0);

        a0 = a_total;
        arm_raw = 1; cycles(30);
        check("sat_a", a_total - a0, 1);
        check("sat_cnt8", int'(if8.trig_cnt), 4);
        check("sat_cnt2", int'(if2.trig_cnt), 3);

        arm_raw = 0; sensor_raw = 0; cycles(15);
        arm_raw = 1; cycles(10);
        check("mid_arming", int'(if8.state), 1);
        rst = 1'b0;
        #1;
        check("rst_state", int'(if8.state), 0);
        check("rst_cnt8", int'(if8.trig_cnt), 0);
        check("rst_cnt2", int'(if2.trig_cnt), 0);
        cycles(2);
        rst = 1'b1;
        cycles(30);

        h_sens = 1; h_ack = 1; h_arm = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (--h_arm == 0) begin arm_raw = ~arm_raw; h_arm = $urandom_range(300, 30); end
            if (--h_sens == 0) begin sensor_raw = ~sensor_raw; h_sens = $urandom_range(60, 1); end
            if (--h_ack == 0) begin ack_raw = ~ack_raw; h_ack = $urandom_range(30, 1); end
            if ($urandom_range(999, 0) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(2, 0) == 0) rst = 1'b1;
        end
        rst = 1'b1; sensor_raw = 0; ack_raw = 0; arm_raw = 0;
        cycles(20);
        check("final_state", int'(if8.state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
